system_0_sysid_ext: RTL and testbench
=====================================

# system_0_sysid_ext

Parametrised system-identification and uptime peripheral on the Qsys Avalon-MM bus, the next generation of the fixed two-word sysid slave. It exposes a build-time system ID, a generation timestamp and a version word. It adds a writable scratch register and a free-running uptime counter with atomic 64-bit readout. Software uses it for image identification, bus sanity checks and coarse timekeeping.

## Interface
- SYSTEM_ID, 32'h00000000: value returned at word 0.
- TIMESTAMP, 32'd1563219222: generation timestamp returned at word 1.
- VERSION, 32'h00010000: major[31:16] / minor[15:0] returned at word 2.
- SCRATCH_RESET, 32'h00000000: reset value of the scratch register.
- CNT_WIDTH, 64: uptime counter width, legal range 33..64.

- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on the clock edge.
- address  in  3  word address.
- read  in  1  read strobe, one transfer per asserted cycle.
- write  in  1  write strobe, one transfer per asserted cycle.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for exactly one cycle per accepted read.

## Operation
- Address map:
  - 0: SYSTEM_ID (RO).
  - 1: TIMESTAMP (RO).
  - 2: VERSION (RO).
  - 3: SCRATCH (RW, per-byte via byteenable).
  - 4: UPTIME_LO (RO, counter[31:0]).
  - 5: UPTIME_HI (RO, shadow).
  - 6: CONTROL (RW).
  - 7: reserved, reads 0.
- CONTROL bits:
  - bit0 EN (RW, reset 1): counter increments each cycle while 1.
  - bit1 CLR (W1, self-clearing, reads 0): forces the counter to 0 on the next edge.
  - Bits [31:2] read 0; writes to them are ignored.
  - byteenable[0]=0 ignores the whole CONTROL write.
- Counter:
  - Increments by 1 per cycle when EN=1.
  - Wraps from all-ones to 0 with no flag.
  - CLR has precedence over increment.
  - An EN=0 write in the same cycle as CLR still clears the counter.
- Atomic readout:
  - A read of address 4 returns counter[31:0] as it stood before that edge's update.
  - The same edge loads the shadow with counter[CNT_WIDTH-1:32], zero-extended to 32 bits.
  - Address 5 returns the shadow only; it does not sample the live counter.
  - The shadow resets to 0.
- Writes to addresses 0,1,2,4,5,7 are ignored.
- A write to SCRATCH updates only the lanes whose byteenable bit is 1.
- Read and write in the same cycle:
  - The write is applied.
  - The read returns the pre-write value, for both SCRATCH and CONTROL.
- When no read is accepted, readdata holds its last value.

## Timing
- Reset values: readdata=0, readdatavalid=0, counter=0, shadow=0, SCRATCH=SCRATCH_RESET, EN=1.
- Reset has priority over read, write and counting.
- Counting starts the first cycle after reset_n is released; the value is 1 one cycle after release.
- Read latency is fixed at 1. With read=1 at edge T, readdata and readdatavalid=1 are valid from T until T+1.
- Back-to-back reads give one readdatavalid per read, in order, with no gaps. No waitrequest is used.
- Write latency is 0: the register value is updated at the edge where write=1.
- Reset asserted with a read in flight: readdatavalid=0 on the following cycle and the read is dropped.

## Test plan
- Reset, then read addresses 0/1/2/7 back-to-back -> SYSTEM_ID, 1563219222, 32'h00010000, 0 on four consecutive readdatavalid cycles.
- Write 32'hA5A5A5A5 with byteenable=4'hF to address 3, then write 32'h000000FF with byteenable=4'b0001, then read -> 32'hA5A5A5FF. Writing address 0 leaves SYSTEM_ID unchanged.
- Reset released at cycle 0, then a read of address 4 issued at cycle 10 -> readdata returns counter[31:0] as stored before edge 10 (value 10). A read of address 5 then returns 0.
- Force the counter (CNT_WIDTH=64) to 64'h00000001_FFFFFFFF, read address 4, wait 5 cycles, read address 5 -> LO=32'hFFFFFFFF, HI=1. The shadow is not affected by the carry.
- Write CONTROL=0, wait 20 cycles, read address 4 twice -> identical values. Then write CONTROL=3 -> the next LO read returns a value of at most 2, and reading CONTROL returns 1.
- Assert reset_n=0 in the cycle after a read -> readdatavalid=0 and the counter is 0. SCRATCH returns SCRATCH_RESET on the next read.

Source files
------------

// File: rtl/system_0_sysid_ext_if.sv
// Avalon-MM slave bus bundle for the sysid/uptime peripheral.
interface system_0_sysid_ext_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/system_0_sysid_ext.sv
// System ID / timestamp / version words, a scratch register and a
// free-running uptime counter whose upper half is latched into a shadow
// whenever the low word is read, so software gets a coherent 64-bit value.
module system_0_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID     = 32'h00000000,
  parameter logic [31:0] TIMESTAMP     = 32'd1563219222,
  parameter logic [31:0] VERSION       = 32'h00010000,
  parameter logic [31:0] SCRATCH_RESET = 32'h00000000,
  parameter int          CNT_WIDTH     = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  system_0_sysid_ext_if.slave  avs
);

  localparam logic [2:0] A_SYSID   = 3'd0;
  localparam logic [2:0] A_TSTAMP  = 3'd1;
  localparam logic [2:0] A_VERSION = 3'd2;
  localparam logic [2:0] A_SCRATCH = 3'd3;
  localparam logic [2:0] A_UP_LO   = 3'd4;
  localparam logic [2:0] A_UP_HI   = 3'd5;
  localparam logic [2:0] A_CONTROL = 3'd6;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          shadow_q, shadow_d;
  logic [31:0]          scratch_q, scratch_d;
  logic                 en_q, en_d;
  logic [31:0]          readdata_q, readdata_d;
  logic                 rdv_q, rdv_d;

  logic [31:0]          rd_mux;
  logic                 clr;
  logic [63:0]          cnt_ext;

  // Widen the counter so the shadow slice is legal for any width 33..64.
  assign cnt_ext = 64'(cnt_q);

  // Read mux sees only pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = 32'h0;
    case (avs.address)
      A_SYSID:   rd_mux = SYSTEM_ID;
      A_TSTAMP:  rd_mux = TIMESTAMP;
      A_VERSION: rd_mux = VERSION;
      A_SCRATCH: rd_mux = scratch_q;
      A_UP_LO:   rd_mux = cnt_q[31:0];
      A_UP_HI:   rd_mux = shadow_q;
      A_CONTROL: rd_mux = {31'h0, en_q};
      default:   rd_mux = 32'h0;
    endcase
  end

  // Next-state for bus registers, control bits, counter and shadow.
  always_comb begin
    readdata_d = readdata_q;
    rdv_d      = avs.read;
    shadow_d   = shadow_q;
    scratch_d  = scratch_q;
    en_d       = en_q;
    clr        = 1'b0;

    if (avs.read) begin
      readdata_d = rd_mux;
      if (avs.address == A_UP_LO)
        shadow_d = cnt_ext[63:32];
    end

    if (avs.write) begin
      if (avs.address == A_SCRATCH) begin
        for (int i = 0; i < 4; i++)
          if (avs.byteenable[i])
            scratch_d[8*i +: 8] = avs.writedata[8*i +: 8];
      end
      // Both control bits live in lane 0; without it the write is dropped.
      if (avs.address == A_CONTROL && avs.byteenable[0]) begin
        en_d = avs.writedata[0];
        clr  = avs.writedata[1];
      end
    end

    // Clear wins over counting, regardless of the EN value being written.
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en_q)
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      shadow_q   <= 32'h0;
      scratch_q  <= SCRATCH_RESET;
      en_q       <= 1'b1;
      readdata_q <= 32'h0;
      rdv_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      scratch_q  <= scratch_d;
      en_q       <= en_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
    end
  end

  assign avs.readdata      = readdata_q;
  assign avs.readdatavalid = rdv_q;

endmodule

// File: tb/tb_system_0_sysid_ext.sv
// Directed bench for system_0_sysid_ext: ID words, scratch lanes, counter
// readout, control bits, read/write collision and reset behaviour.
module tb_system_0_sysid_ext;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  system_0_sysid_ext_if bus();

  system_0_sysid_ext #(.CNT_WIDTH(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .avs     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.read = 1'b0; bus.write = 1'b0; bus.address = 3'd0;
    bus.writedata = 32'h0; bus.byteenable = 4'h0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    bus.write = 1'b1; bus.address = a; bus.writedata = d; bus.byteenable = be;
    @(negedge clock);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clock);
    bus.read = 1'b1; bus.address = a;
    @(negedge clock);
    bus.read = 1'b0;
    check("rdv", 64'(bus.readdatavalid), 64'd1);
    d = bus.readdata;
  endtask

  logic [31:0] v, v2;
  logic [2:0]  id_addr [4];
  logic [31:0] id_exp  [4];

  initial begin
    id_addr = '{3'd0, 3'd1, 3'd2, 3'd7};
    id_exp  = '{32'h00000000, 32'd1563219222, 32'h00010000, 32'h0};
    idle_bus();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_rdata", 64'(bus.readdata), 64'd0);
    check("rst_rdv", 64'(bus.readdatavalid), 64'd0);

    // Release just before edge 0; edge 0 takes the counter to 1.
    reset_n = 1'b1;
    repeat (9) @(negedge clock);
    bus_read(3'd4, v);
    check("uptime_lo_at_10", 64'(v), 64'd10);
    bus_read(3'd5, v);
    check("uptime_hi_zero", 64'(v), 64'd0);

    // Back-to-back ID reads, one valid per read with no gaps.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clock);
      if (i > 0) begin
        check("id_rdv", 64'(bus.readdatavalid), 64'd1);
        check("id_word", 64'(bus.readdata), 64'(id_exp[i-1]));
      end
      if (i < 4) begin
        bus.read = 1'b1; bus.address = id_addr[i];
      end else
        bus.read = 1'b0;
    end
    @(negedge clock);
    check("rdv_idle", 64'(bus.readdatavalid), 64'd0);
    check("rdata_hold", 64'(bus.readdata), 64'd0);

    // Scratch byte lanes and read-only ID.
    bus_write(3'd3, 32'hA5A5A5A5, 4'hF);
    bus_write(3'd3, 32'h000000FF, 4'b0001);
    bus_read(3'd3, v);
    check("scratch_lanes", 64'(v), 64'hA5A5A5FF);
    bus_write(3'd0, 32'hDEADBEEF, 4'hF);
    bus_read(3'd0, v);
    check("sysid_ro", 64'(v), 64'h0);

    // Same-cycle read and write of SCRATCH returns the old value.
    @(negedge clock);
    bus.read = 1'b1; bus.write = 1'b1; bus.address = 3'd3;
    bus.writedata = 32'h12345678; bus.byteenable = 4'hF;
    @(negedge clock);
    idle_bus();
    check("rw_old", 64'(bus.readdata), 64'hA5A5A5FF);
    bus_read(3'd3, v);
    check("rw_new", 64'(v), 64'h12345678);

    // Force the counter to 1_FFFFFFFF across the edge of a LO read.
    @(negedge clock);
    force dut.cnt_q = 64'h00000001_FFFFFFFF;
    bus.read = 1'b1; bus.address = 3'd4;
    @(negedge clock);
    bus.read = 1'b0;
    release dut.cnt_q;
    check("force_lo", 64'(bus.readdata), 64'hFFFFFFFF);
    repeat (5) @(negedge clock);
    bus_read(3'd5, v);
    check("force_hi_shadow", 64'(v), 64'd1);

    // Stop the counter, then clear and restart it.
    bus_write(3'd6, 32'h0, 4'h1);
    repeat (20) @(negedge clock);
    bus_read(3'd4, v);
    bus_read(3'd4, v2);
    check("stopped_stable", 64'(v2), 64'(v));
    bus_read(3'd6, v);
    check("ctrl_en0", 64'(v), 64'd0);
    bus_write(3'd6, 32'h3, 4'h1);
    bus_read(3'd4, v);
    check("clr_small", 64'(v <= 32'd2), 64'd1);
    bus_read(3'd6, v);
    check("ctrl_reads_1", 64'(v), 64'd1);
    bus_write(3'd6, 32'h0, 4'b1110);
    bus_read(3'd6, v);
    check("ctrl_be0_ignored", 64'(v), 64'd1);

    // Clear in the same write that disables: counter must still clear.
    repeat (5) @(negedge clock);
    bus_write(3'd6, 32'h2, 4'h1);
    bus_read(3'd4, v);
    check("clr_with_en0", 64'(v), 64'd0);

    // Reset the cycle after a read: valid drops, state returns to reset.
    @(negedge clock);
    bus.read = 1'b1; bus.address = 3'd3;
    @(negedge clock);
    bus.read = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    check("rst_drop_rdv", 64'(bus.readdatavalid), 64'd0);
    check("rst_drop_rdata", 64'(bus.readdata), 64'd0);
    reset_n = 1'b1;
    bus.read = 1'b1; bus.address = 3'd4;
    @(negedge clock);
    bus.read = 1'b0;
    check("rst_cnt_zero", 64'(bus.readdata), 64'd0);
    bus_read(3'd3, v);
    check("rst_scratch", 64'(v), 64'h0);
    bus_read(3'd6, v);
    check("rst_en", 64'(v), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
